// File: rtl/keccak_absorb_feeder.sv
// Keccak absorb feeder: fetches message lanes from dual-port RAM, applies
// multi-rate padding and streams 64-bit lanes, block by block, into the core.

module keccak_pad_byte #(
  parameter logic [7:0] PAD_DS     = 8'h1F,
  parameter int         RATE_BYTES = 168
) (
  input  logic [7:0]  ram_byte,
  input  logic [15:0] r,
  input  logic [15:0] rem,
  input  logic        final_blk,
  output logic [7:0]  pad_byte
);
  always_comb begin
    pad_byte = 8'h00;
    if (r < rem)
      pad_byte = ram_byte;
    else if (final_blk && (r == rem))
      pad_byte = PAD_DS;
    // The closing 0x80 merges with the DS byte when both land on the last rate byte.
    if (final_blk && (r == 16'(RATE_BYTES - 1)))
      pad_byte = pad_byte | 8'h80;
  end
endmodule

module keccak_absorb_feeder #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         RATE_LANES = 21,
  parameter logic [7:0] PAD_DS     = 8'h1F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           msg_len_byte,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  input  logic [DATA_WIDTH-1:0] mem_rdata_a,
  output logic                  mem_en_b,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [DATA_WIDTH-1:0] mem_rdata_b,
  output logic [63:0]           din,
  output logic                  din_valid,
  input  logic                  buffer_full,
  output logic                  last_block
);
  localparam int RATE_BYTES = 8 * RATE_LANES;
  localparam int LW         = $clog2(RATE_LANES);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, PUSH, WAITB, LAST, DONE
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] wp;
  logic [15:0]           rem;
  logic [LW-1:0]         lane;
  logic                  eom;

  logic [15:0]           lane_off;
  logic                  final_blk;
  logic                  lane_has_data;
  logic                  last_lane;
  logic [63:0]           raw_lane;
  logic [7:0][7:0]       pad_lane;

  assign lane_off      = 16'(lane) << 3;
  assign final_blk     = rem < 16'(RATE_BYTES);
  assign lane_has_data = lane_off < rem;
  assign last_lane     = lane == LW'(RATE_LANES - 1);
  assign raw_lane      = lane_has_data ? {mem_rdata_b, mem_rdata_a} : 64'h0;

  genvar j;
  generate
    for (j = 0; j < 8; j++) begin : g_pad
      keccak_pad_byte #(
        .PAD_DS     (PAD_DS),
        .RATE_BYTES (RATE_BYTES)
      ) u_pad (
        .ram_byte  (raw_lane[8*j +: 8]),
        .r         (lane_off + 16'(j)),
        .rem       (rem),
        .final_blk (final_blk),
        .pad_byte  (pad_lane[j])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = PUSH;
      PUSH:    if (!buffer_full) state_nx = last_lane ? WAITB : FETCH;
      WAITB:   if (!buffer_full) state_nx = eom ? LAST : FETCH;
      LAST:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = state == DONE;
  assign din_valid  = state == PUSH;
  assign last_block = state == LAST;
  // Lanes made purely of padding never touch the RAM.
  assign mem_en_a   = (state == FETCH) && lane_has_data;
  assign mem_en_b   = mem_en_a;
  assign mem_addr_a = (state == IDLE) ? '0 : wp;
  assign mem_addr_b = (state == IDLE) ? '0 : wp + ADDR_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= '0;
      rem  <= '0;
      lane <= '0;
      eom  <= 1'b0;
      din  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          wp   <= base_addr;
          rem  <= msg_len_byte;
          lane <= '0;
          eom  <= 1'b0;
        end
        LOAD: din <= pad_lane;
        PUSH: if (!buffer_full) begin
          wp <= wp + ADDR_WIDTH'(2);
          if (last_lane) begin
            lane <= '0;
            // eom remembers the just-finished block was final; rem is stale by then.
            if (final_blk) eom <= 1'b1;
            else           rem <= rem - 16'(RATE_BYTES);
          end else begin
            lane <= lane + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_absorb_feeder.sv
// Table-driven bench for keccak_absorb_feeder: RAM model, lane scoreboard
// against a byte-level padding model, plus back-pressure and reset sequences.

module tb_keccak_absorb_feeder;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [31:0] base_addr = 0;
  logic [15:0] msg_len_byte = 0;
  logic        busy, done, mem_en_a, mem_en_b, din_valid, last_block;
  logic [31:0] mem_addr_a, mem_addr_b, mem_rdata_a, mem_rdata_b;
  logic [63:0] din;
  logic        buffer_full = 0;

  keccak_absorb_feeder #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .RATE_LANES (21), .PAD_DS (8'h1F)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .base_addr (base_addr),
    .msg_len_byte (msg_len_byte), .busy (busy), .done (done),
    .mem_en_a (mem_en_a), .mem_addr_a (mem_addr_a), .mem_rdata_a (mem_rdata_a),
    .mem_en_b (mem_en_b), .mem_addr_b (mem_addr_b), .mem_rdata_b (mem_rdata_b),
    .din (din), .din_valid (din_valid), .buffer_full (buffer_full),
    .last_block (last_block)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [2048];
  always @(posedge clk) begin
    if (mem_en_a) mem_rdata_a <= mem[mem_addr_a[10:0]];
    if (mem_en_b) mem_rdata_b <= mem[mem_addr_b[10:0]];
  end

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  logic [63:0] lanes[$];
  int first_vld, last_xfer_cyc, rd_cnt, addr_err, hold_err, bf_rd;
  int lb_cnt, lb_cyc, dn_cnt, dn_cyc, busy_err;
  logic [31:0] cur_base;
  bit held = 0;
  logic [63:0] held_din;
  logic [31:0] held_addr;
  int bf_mode = 0, bf_hold = 0;
  bit bf_fired = 0;

  always @(negedge clk) begin
    if (din_valid && !buffer_full) begin lanes.push_back(din); last_xfer_cyc = cyc; end
    if (din_valid && first_vld < 0) first_vld = cyc;
    if (held && (!din_valid || din !== held_din || mem_addr_a !== held_addr)) hold_err++;
    held = din_valid && buffer_full;
    held_din = din;
    held_addr = mem_addr_a;
    if (mem_en_a || mem_en_b) begin
      rd_cnt++;
      if (mem_en_a !== mem_en_b || mem_addr_b !== mem_addr_a + 32'd1 ||
          mem_addr_a !== cur_base + 32'(2 * lanes.size())) addr_err++;
      if (buffer_full) bf_rd++;
    end
    if (last_block) begin lb_cnt++; lb_cyc = cyc; end
    if (done) begin dn_cnt++; dn_cyc = cyc; if (busy) busy_err++; end
  end

  // back-pressure driver: mode 1 stalls between blocks, mode 2 stalls lane 3
  always @(posedge clk) begin
    #1;
    if (bf_hold > 0) begin
      buffer_full = 1; bf_hold--;
    end else begin
      buffer_full = 0;
      if (bf_mode == 2 && din_valid && lanes.size() == 3 && !bf_fired) begin
        bf_fired = 1; buffer_full = 1; bf_hold = 4;
      end
      if (bf_mode == 1 && lanes.size() == 21 && !bf_fired) begin
        bf_fired = 1; buffer_full = 1; bf_hold = 9;
      end
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] lane_at(input int idx);
    if (idx < lanes.size()) return lanes[idx];
    return 64'hx;
  endfunction

  function automatic logic [63:0] model_lane(input logic [31:0] base, input int len, input int idx);
    logic [63:0] v;
    logic [31:0] w, word;
    int total, g;
    logic [7:0] b;
    total = (len / 168 + 1) * 168;
    v = 0;
    for (int j = 0; j < 8; j++) begin
      g = idx * 8 + j;
      b = 8'h00;
      if (g < len) begin
        w = base + 32'(g / 4);
        word = mem[w[10:0]];
        b = word[8*(g%4) +: 8];
      end
      if (g == len) b = b ^ 8'h1F;
      if (g == total - 1) b = b | 8'h80;
      v[8*j +: 8] = b;
    end
    return v;
  endfunction

  typedef struct {
    logic [31:0] base;
    int          len;
    int          bf_mode;
    bit          restart;
    int          n_lanes;
    int          n_reads;
    logic [63:0] first;
    int          chk_idx;
    logic [63:0] chk_val;
    logic [63:0] last;
  } vec_t;

  task automatic run_vec(input vec_t v, input string name);
    bit fin;
    int st_cyc;
    lanes.delete();
    first_vld = -1; last_xfer_cyc = -1; rd_cnt = 0; addr_err = 0; hold_err = 0;
    bf_rd = 0; lb_cnt = 0; lb_cyc = -1; dn_cnt = 0; dn_cyc = -1; busy_err = 0;
    bf_mode = v.bf_mode; bf_fired = 0; cur_base = v.base;
    @(posedge clk); #1;
    base_addr = v.base; msg_len_byte = 16'(v.len); start = 1; st_cyc = cyc;
    @(posedge clk); #1;
    start = 0; base_addr = 32'h0BAD_0000; msg_len_byte = 16'h1234;
    chk({name, " busy_after_start"}, 64'(busy), 64'd1);
    fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (done) fin = 1;
      // a start while busy must be ignored
      start = (v.restart && c == 6);
      base_addr = 32'h0; msg_len_byte = 16'h0;
    end
    start = 0;
    chk({name, " finished_in_budget"}, 64'(fin), 64'd1);
    repeat (3) @(negedge clk);
    chk({name, " lane_count"}, 64'(lanes.size()), 64'(v.n_lanes));
    chk({name, " lane0"}, lane_at(0), v.first);
    chk($sformatf("%s lane%0d", name, v.chk_idx), lane_at(v.chk_idx), v.chk_val);
    chk({name, " final_lane"}, lane_at(v.n_lanes - 1), v.last);
    for (int i = 0; i < v.n_lanes; i++)
      chk($sformatf("%s model_lane%0d", name, i), lane_at(i), model_lane(v.base, v.len, i));
    chk({name, " read_count"}, 64'(rd_cnt), 64'(v.n_reads));
    chk({name, " read_addr_errors"}, 64'(addr_err), 64'd0);
    chk({name, " hold_stability_errors"}, 64'(hold_err), 64'd0);
    chk({name, " reads_while_full"}, 64'(bf_rd), 64'd0);
    chk({name, " start_to_valid"}, 64'(first_vld - st_cyc), 64'd3);
    chk({name, " last_block_pulses"}, 64'(lb_cnt), 64'd1);
    chk({name, " last_block_timing"}, 64'(lb_cyc - last_xfer_cyc), 64'd2);
    chk({name, " done_pulses"}, 64'(dn_cnt), 64'd1);
    chk({name, " done_after_last"}, 64'(dn_cyc - lb_cyc), 64'd1);
    chk({name, " busy_with_done"}, 64'(busy_err), 64'd0);
    chk({name, " busy_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, " busy"}, 64'(busy), 64'd0);
    chk({name, " done"}, 64'(done), 64'd0);
    chk({name, " din_valid"}, 64'(din_valid), 64'd0);
    chk({name, " last_block"}, 64'(last_block), 64'd0);
    chk({name, " mem_en"}, 64'({mem_en_a, mem_en_b}), 64'd0);
    chk({name, " addrs"}, {mem_addr_a, mem_addr_b}, 64'd0);
    chk({name, " din"}, din, 64'd0);
  endtask

  vec_t tbl[6];
  vec_t t6;

  initial begin
    bit fin;
    for (int w = 0; w < 2048; w++) begin
      logic [7:0] lo;
      lo = 8'(w);
      mem[w] = {lo + 8'd3, lo + 8'd2, lo + 8'd1, lo};
    end
    mem[16'h10] = 32'h0403_0201;
    mem[16'h11] = 32'h0807_0605;

    tbl[0] = '{base: 32'h40,  len: 0,   bf_mode: 0, restart: 0, n_lanes: 21, n_reads: 0,
               first: 64'h0000_0000_0000_001F, chk_idx: 1, chk_val: 64'h0,
               last: 64'h8000_0000_0000_0000};
    tbl[1] = '{base: 32'h10,  len: 5,   bf_mode: 0, restart: 0, n_lanes: 21, n_reads: 1,
               first: 64'h0000_1F05_0403_0201, chk_idx: 1, chk_val: 64'h0,
               last: 64'h8000_0000_0000_0000};
    tbl[2] = '{base: 32'h100, len: 167, bf_mode: 0, restart: 1, n_lanes: 21, n_reads: 21,
               first: 64'h0403_0201_0302_0100, chk_idx: 19, chk_val: 64'h2A29_2827_2928_2726,
               last: 64'h9F2B_2A29_2B2A_2928};
    tbl[3] = '{base: 32'h200, len: 168, bf_mode: 1, restart: 0, n_lanes: 42, n_reads: 21,
               first: 64'h0403_0201_0302_0100, chk_idx: 21, chk_val: 64'h0000_0000_0000_001F,
               last: 64'h8000_0000_0000_0000};
    tbl[4] = '{base: 32'h300, len: 40,  bf_mode: 2, restart: 0, n_lanes: 21, n_reads: 5,
               first: 64'h0403_0201_0302_0100, chk_idx: 3, chk_val: 64'h0A09_0807_0908_0706,
               last: 64'h8000_0000_0000_0000};
    tbl[5] = '{base: 32'h500, len: 175, bf_mode: 0, restart: 0, n_lanes: 42, n_reads: 22,
               first: 64'h0403_0201_0302_0100, chk_idx: 21, chk_val: 64'h1F2D_2C2B_2D2C_2B2A,
               last: 64'h8000_0000_0000_0000};
    t6     = '{base: 32'h400, len: 8,   bf_mode: 0, restart: 0, n_lanes: 21, n_reads: 1,
               first: 64'h0403_0201_0302_0100, chk_idx: 1, chk_val: 64'h0000_0000_0000_001F,
               last: 64'h8000_0000_0000_0000};

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 0;

    for (int t = 0; t < 6; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // reset in the middle of a long message, then a fresh short one
    lanes.delete(); bf_mode = 0; cur_base = 32'h600;
    @(posedge clk); #1;
    base_addr = 32'h600; msg_len_byte = 16'd300; start = 1;
    @(posedge clk); #1;
    start = 0;
    fin = 0;
    for (int c = 0; c < 500 && !fin; c++) begin
      @(negedge clk);
      if (lanes.size() >= 10) fin = 1;
    end
    chk("midreset reached_lane10", 64'(fin), 64'd1);
    #2 rst = 1;
    #1 chk_zero_outputs("midreset");
    @(negedge clk) rst = 0;
    run_vec(t6, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
